// File: rtl/addsub_response_checker.sv
// addsub_response_checker
// Response end of the adder/subtractor stimulus path. Recomputes the expected {S,C,V} for each
// accepted {A,B,M} sample, reports a mismatch one cycle later, counts vectors and errors, captures
// the first failing vector and declares completion after 2^(2W+1) samples.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   clr             synchronous sweep restart, same effect as rst
//   in_valid        A,B,M,S,C,V form a valid sample this cycle
//   A, B, M         operands and mode (0 = add, 1 = subtract) applied to the DUT
//   S, C, V         DUT sum/difference, carry-out, signed overflow
//   mismatch        1-cycle pulse: the previous cycle's sample was wrong
//   err_cnt         saturating count of mismatching samples
//   vec_cnt         count of accepted samples
//   first_err_vld   first_err_vec holds a captured failure
//   first_err_vec   {A,B,M} of the first mismatching sample
//   done            sweep complete
//   all_pass        done with no errors
module addsub_response_checker #(
  parameter int unsigned W     = 4,
  parameter int unsigned ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic             M,
  input  logic [W-1:0]     S,
  input  logic             C,
  input  logic             V,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2*W+1:0]   vec_cnt,
  output logic             first_err_vld,
  output logic [2*W:0]     first_err_vec,
  output logic             done,
  output logic             all_pass
);

  localparam int unsigned VecW = 2 * W + 2;
  // Value of vec_cnt just before the final sample of the sweep: 2^(2W+1) - 1.
  localparam logic [VecW-1:0] LastVec = {1'b0, {(2 * W + 1){1'b1}}};

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic               mismatch_q;
  logic [ERR_W-1:0]   err_cnt_q;
  logic [VecW-1:0]    vec_cnt_q;
  logic               first_err_vld_q;
  logic [2*W:0]       first_err_vec_q;

  // Golden model
  logic [W-1:0] bx;
  logic [W:0]   sum_e;
  logic         v_e;
  logic         bad;
  logic         accept;
  logic         restart;

  assign bx      = M ? ~B : B;
  assign sum_e   = {1'b0, A} + {1'b0, bx} + (W+1)'(M);
  assign v_e     = (A[W-1] == bx[W-1]) && (sum_e[W-1] != A[W-1]);
  assign bad     = {S, C, V} != {sum_e[W-1:0], sum_e[W], v_e};
  assign restart = rst | clr;
  // Samples are taken in IDLE (first one starts the run) and RUN; DONE ignores inputs.
  assign accept  = in_valid && (state_q != StDone);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun:   if (in_valid && vec_cnt_q == LastVec) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      // Also discards the compare of any sample presented alongside clr.
      state_q         <= StIdle;
      mismatch_q      <= 1'b0;
      err_cnt_q       <= '0;
      vec_cnt_q       <= '0;
      first_err_vld_q <= 1'b0;
      first_err_vec_q <= '0;
    end else begin
      state_q    <= state_d;
      mismatch_q <= accept && bad;
      if (accept) begin
        vec_cnt_q <= vec_cnt_q + VecW'(1);
        if (bad) begin
          if (!(&err_cnt_q)) err_cnt_q <= err_cnt_q + ERR_W'(1);
          if (!first_err_vld_q) begin
            first_err_vld_q <= 1'b1;
            first_err_vec_q <= {A, B, M};
          end
        end
      end
    end
  end

  assign mismatch      = mismatch_q;
  assign err_cnt       = err_cnt_q;
  assign vec_cnt       = vec_cnt_q;
  assign first_err_vld = first_err_vld_q;
  assign first_err_vec = first_err_vec_q;
  assign done          = (state_q == StDone);
  assign all_pass      = (state_q == StDone) && (err_cnt_q == '0);

endmodule

// File: tb/tb_addsub_response_checker.sv
module tb_addsub_response_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] A = '0, B = '0, S = '0;
  logic       M = 1'b0, C = 1'b0, V = 1'b0;

  logic        mismatch, first_err_vld, done, all_pass;
  logic [15:0] err_cnt;
  logic [9:0]  vec_cnt;
  logic [8:0]  first_err_vec;

  logic        mismatch2, first_err_vld2, done2, all_pass2;
  logic [1:0]  err_cnt2;
  logic [9:0]  vec_cnt2;
  logic [8:0]  first_err_vec2;

  always #5 clk = ~clk;

  addsub_response_checker #(.W(4), .ERR_W(16)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
    .A(A), .B(B), .M(M), .S(S), .C(C), .V(V),
    .mismatch(mismatch), .err_cnt(err_cnt), .vec_cnt(vec_cnt),
    .first_err_vld(first_err_vld), .first_err_vec(first_err_vec),
    .done(done), .all_pass(all_pass)
  );

  // Narrow error counter to exercise saturation.
  addsub_response_checker #(.W(4), .ERR_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
    .A(A), .B(B), .M(M), .S(S), .C(C), .V(V),
    .mismatch(mismatch2), .err_cnt(err_cnt2), .vec_cnt(vec_cnt2),
    .first_err_vld(first_err_vld2), .first_err_vec(first_err_vec2),
    .done(done2), .all_pass(all_pass2)
  );

  typedef struct {
    bit mis;
    int vec;
    int err;
    int err2;
    bit done;
    bit fvld;
    int fvec;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int pulses2 = 0;

  // Model state
  int m_vec, m_err, m_err2, m_fvec;
  bit m_fvld, m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference arithmetic done with integers rather than the bit-level formula.
  task automatic golden(input logic [3:0] a, input logic [3:0] b, input logic m,
                        output logic [3:0] s, output logic c, output logic v);
    int ia, ib, sa, sb_, r, rs;
    ia  = int'(a);
    ib  = int'(b);
    sa  = (ia > 7) ? ia - 16 : ia;
    sb_ = (ib > 7) ? ib - 16 : ib;
    if (m) begin
      r  = ia - ib;
      c  = (ia >= ib);
      rs = sa - sb_;
    end else begin
      r  = ia + ib;
      c  = (r > 15);
      rs = sa + sb_;
    end
    s = 4'(r);
    v = (rs > 7) || (rs < -8);
  endtask

  task automatic model_reset();
    m_vec = 0; m_err = 0; m_err2 = 0; m_fvec = 0; m_fvld = 0; m_done = 0;
  endtask

  function automatic exp_t snapshot(input bit mis);
    exp_t e;
    e.mis = mis; e.vec = m_vec; e.err = m_err; e.err2 = m_err2;
    e.done = m_done; e.fvld = m_fvld; e.fvec = m_fvec;
    return e;
  endfunction

  task automatic compare(input exp_t e);
    chk("mismatch", 32'(mismatch), 32'(e.mis));
    chk("vec_cnt", 32'(vec_cnt), e.vec);
    chk("err_cnt", 32'(err_cnt), e.err);
    chk("first_err_vld", 32'(first_err_vld), 32'(e.fvld));
    chk("first_err_vec", 32'(first_err_vec), e.fvec);
    chk("done", 32'(done), 32'(e.done));
    chk("all_pass", 32'(all_pass), 32'(e.done && e.err == 0));
    chk("sat_mismatch", 32'(mismatch2), 32'(e.mis));
    chk("sat_err_cnt", 32'(err_cnt2), e.err2);
    chk("sat_misc", {19'd0, vec_cnt2, done2, all_pass2, first_err_vld2},
        {19'd0, 10'(e.vec), e.done, e.done && e.err == 0, e.fvld});
    chk("sat_first_vec", 32'(first_err_vec2), e.fvec);
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0;
    model_reset();
    sb.push_back(snapshot(1'b0));
    @(posedge clk); #1;
    rst = 1'b0;
    compare(sb.pop_front());
  endtask

  // Drive one cycle; the model predicts and queues the response, which is popped after the edge.
  task automatic step(input logic iv, input logic cl, input logic [3:0] a, input logic [3:0] b,
                      input logic m, input logic [3:0] s, input logic c, input logic v);
    logic [3:0] gs;
    logic gc, gv, bad, mis;
    in_valid = iv; clr = cl; A = a; B = b; M = m; S = s; C = c; V = v;
    golden(a, b, m, gs, gc, gv);
    bad = {s, c, v} != {gs, gc, gv};
    mis = 1'b0;
    if (cl) begin
      model_reset();
    end else if (iv && !m_done) begin
      m_vec++;
      mis = bad;
      if (bad) begin
        if (m_err < 65535) m_err++;
        if (m_err2 < 3) m_err2++;
        if (!m_fvld) begin
          m_fvld = 1'b1;
          m_fvec = 32'({a, b, m});
        end
      end
      if (m_vec == 512) m_done = 1'b1;
    end
    sb.push_back(snapshot(mis));
    @(posedge clk); #1;
    in_valid = 1'b0; clr = 1'b0;
    if (mismatch2) pulses2++;
    compare(sb.pop_front());
  endtask

  task automatic sweep_step(input int idx, input bit v_stuck0, input bit cl);
    logic [8:0] vv;
    logic [3:0] gs;
    logic gc, gv;
    vv = 9'(idx);
    golden(vv[8:5], vv[4:1], vv[0], gs, gc, gv);
    step(1'b1, cl, vv[8:5], vv[4:1], vv[0], gs, gc, v_stuck0 ? 1'b0 : gv);
  endtask

  initial begin
    int nve, first_ve;
    logic [8:0] vv;
    logic [3:0] gs;
    logic gc, gv;

    // Reset state
    do_reset();

    // T1: 7+1 overflows signed; correct DUT response
    step(1'b1, 1'b0, 4'd7, 4'd1, 1'b0, 4'd8, 1'b0, 1'b1);
    // in_valid low: nothing changes
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);

    // T2: 3-5 correct, then the same with a wrong carry
    step(1'b1, 1'b0, 4'd3, 4'd5, 1'b1, 4'd14, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd3, 4'd5, 1'b1, 4'd14, 1'b1, 1'b0);
    chk("t2_first_vec", 32'(first_err_vec), 32'({4'd3, 4'd5, 1'b1}));
    // Another fault must not overwrite the captured vector
    step(1'b1, 1'b0, 4'd2, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("t2_first_hold", 32'(first_err_vec), 32'({4'd3, 4'd5, 1'b1}));

    // T3: full correct sweep, back-to-back
    do_reset();
    for (int i = 0; i < 512; i++) sweep_step(i, 1'b0, 1'b0);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_all_pass", 32'(all_pass), 32'd1);
    chk("t3_vec", 32'(vec_cnt), 32'd512);
    step(1'b1, 1'b0, 4'd1, 4'd1, 1'b0, 4'd7, 1'b0, 1'b0);
    chk("t3_vec_hold", 32'(vec_cnt), 32'd512);

    // T4: V stuck at 0
    nve = 0;
    first_ve = -1;
    for (int i = 0; i < 512; i++) begin
      vv = 9'(i);
      golden(vv[8:5], vv[4:1], vv[0], gs, gc, gv);
      if (gv) begin
        nve++;
        if (first_ve < 0) first_ve = i;
      end
    end
    do_reset();
    for (int i = 0; i < 512; i++) sweep_step(i, 1'b1, 1'b0);
    chk("t4_err", 32'(err_cnt), nve);
    chk("t4_all_pass", 32'(all_pass), 32'd0);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_first_vec", 32'(first_err_vec), first_ve);

    // T5: clr together with a faulty sample at vec_cnt=100
    do_reset();
    for (int i = 0; i < 100; i++) sweep_step(i, 1'b0, 1'b0);
    chk("t5_vec100", 32'(vec_cnt), 32'd100);
    step(1'b1, 1'b1, 4'd7, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("t5_vec", 32'(vec_cnt), 32'd0);
    chk("t5_mismatch", 32'(mismatch), 32'd0);
    // Back in IDLE: the next sample restarts the count
    sweep_step(5, 1'b0, 1'b0);
    chk("t5_restart", 32'(vec_cnt), 32'd1);

    // T6: 5 faults into a 2-bit error counter
    do_reset();
    pulses2 = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'(i), 4'd1, 1'b0, 4'd0, 1'b1, 1'b1);
    chk("t6_err_sat", 32'(err_cnt2), 32'd3);
    chk("t6_pulses", pulses2, 32'd5);
    chk("t6_err_wide", 32'(err_cnt), 32'd5);

    // Reset mid-sweep right after a faulty sample: no lingering pulse
    step(1'b1, 1'b0, 4'd1, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
